// File: rtl/route_player_if.sv
// route_player_if: bundles the route-player control and feedback signals.
//   master : the side that programs the route and supplies the nav FSM's
//            dout feedback (bench or system controller)
//   slave  : route_player itself
//   wr_en/wr_data          append a location code to the route
//   clear/start/abort      playback control
//   din_out/dout_fb        code to the navigation FSM and its combinational reply
//   busy/done/err          playback status
//   err_idx/cur_idx/count/full  route indices and fill level
interface route_player_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             wr_en;
  logic [2:0]       wr_data;
  logic             clear;
  logic             start;
  logic             abort;
  logic [2:0]       din_out;
  logic [2:0]       dout_fb;
  logic             busy;
  logic             done;
  logic             err;
  logic [PTR_W-1:0] err_idx;
  logic [PTR_W-1:0] cur_idx;
  logic [PTR_W:0]   count;
  logic             full;

  modport master (
    output wr_en, wr_data, clear, start, abort, dout_fb,
    input  din_out, busy, done, err, err_idx, cur_idx, count, full
  );

  modport slave (
    input  wr_en, wr_data, clear, start, abort, dout_fb,
    output din_out, busy, done, err, err_idx, cur_idx, count, full
  );
endinterface

// File: rtl/route_player.sv
// route_player: stores a route of 3-bit location codes and plays it into the
// navigation FSM, one code per TICK_DIV-cycle step window, checking each step
// against the FSM's dout feedback and halting on the first rejected move.
//   clk   system clock (rising edge)
//   rstn  asynchronous active-low reset
//   bus   route_player_if.slave (route programming, control, status, din/dout)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no playback; route may be written; start accepted if count > 0
// ISSUE  | one cycle: compare dout_fb against the code just driven
// WAIT   | hold the code for the rest of the step window
// DONE   | whole route accepted; done held until start/clear
// ERROR  | a step was rejected; err/err_idx held until start/clear
module route_player #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 4
) (
  input logic           clk,
  input logic           rstn,
  route_player_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = (TICK_DIV > 2) ? $clog2(TICK_DIV - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       din_q, din_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] cur_q, cur_d;
  logic [PTR_W-1:0] err_idx_q, err_idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       mem_q [DEPTH];

  logic             full;
  logic             busy;
  logic             wr_accept;
  logic             cur_is_last;
  logic [PTR_W-1:0] nxt_idx;

  assign full        = (count_q == (PTR_W+1)'(DEPTH));
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign nxt_idx     = cur_q + PTR_W'(1);
  assign cur_is_last = ({1'b0, cur_q} == (count_q - (PTR_W+1)'(1)));

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    count_d   = count_q;
    cur_d     = cur_q;
    err_idx_d = err_idx_q;
    done_d    = done_q;
    err_d     = err_q;
    tmr_d     = tmr_q;
    wr_accept = 1'b0;

    if (bus.clear) begin
      // din_out deliberately held: the nav FSM stays parked on the last code
      state_d = S_IDLE;
      count_d = '0;
      cur_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (bus.abort) begin
      // abort outranks start/write even outside playback
      if (busy) state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start && (count_q != '0)) begin
            state_d = S_ISSUE;
            cur_d   = '0;
            din_d   = mem_q[0];
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else if (bus.wr_en && !full) begin
            wr_accept = 1'b1;
            count_d   = count_q + (PTR_W+1)'(1);
          end
        end
        S_ISSUE: begin
          // 000 is also the nav FSM's default output, so it can't be judged
          if ((bus.dout_fb == din_q) || (din_q == 3'b000)) begin
            state_d = S_WAIT;
            tmr_d   = TMR_W'(TICK_DIV - 2);
          end else begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            err_idx_d = cur_q;
          end
        end
        S_WAIT: begin
          if (tmr_q == '0) begin
            if (cur_is_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ISSUE;
              cur_d   = nxt_idx;
              din_d   = mem_q[nxt_idx];
            end
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      din_q     <= 3'b000;
      count_q   <= '0;
      cur_q     <= '0;
      err_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      count_q   <= count_d;
      cur_q     <= cur_d;
      err_idx_q <= err_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmr_q     <= tmr_d;
    end
  end

  // Route storage needs no reset; count_q defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[count_q[PTR_W-1:0]] <= bus.wr_data;
  end

  assign bus.din_out = din_q;
  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_idx = err_idx_q;
  assign bus.cur_idx = cur_q;
  assign bus.count   = count_q;
  assign bus.full    = full;
endmodule

// File: doc/route_player.md
Name: route_player

Overview:
- Upstream stimulus stage for the campus-location navigation FSM (3-bit location codes, S0..S7).
- Stores a programmed route of location codes and plays it into the FSM `din`, one code per step window.
- Checks each step against the FSM's `dout` feedback and halts on the first rejected move.
- Used for board demos and as a reusable driver in system benches.

Parameters:
- DEPTH, 8, maximum number of route entries (power of two, ≥2).
- TICK_DIV, 4, clock cycles per step window (≥2).
- PTR_W, $clog2(DEPTH), index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  append `wr_data` to the route.
- wr_data  in  3  location code to append.
- clear  in  1  empty the route, return to IDLE.
- start  in  1  begin playback from index 0.
- abort  in  1  stop playback, keep the route.
- din_out  out  3  code driven to the navigation FSM `din`.
- dout_fb  in  3  navigation FSM `dout`, combinational feedback.
- busy  out  1  high in ISSUE/WAIT.
- done  out  1  high in DONE.
- err  out  1  high in ERROR.
- err_idx  out  PTR_W  index of the rejected step.
- cur_idx  out  PTR_W  index of the step being played.
- count  out  PTR_W+1  number of stored entries.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, rstn=0):
  - FSM state = IDLE.
  - din_out = 3'b000, count = 0, cur_idx = 0, err_idx = 0.
  - busy, done, err, full = 0.
  - Route memory contents are don't-care.
- All outputs are registered except `full` and `busy`, which are decoded from registers.
- States: IDLE, ISSUE, WAIT, DONE, ERROR.
- Writes:
  - Accepted only in IDLE/DONE/ERROR, with clear=0 and full=0.
  - An accepted write stores `wr_data` at index `count` and increments `count`.
  - wr_en in ISSUE/WAIT, or when full, is dropped silently.
  - Writes made in DONE/ERROR are played on the next start.
- start:
  - Honoured in IDLE/DONE/ERROR only when count > 0; otherwise ignored.
  - Clears done/err, sets cur_idx = 0, loads din_out = route[0], enters ISSUE.
- Step timing: with start sampled at edge E0, din_out = route[k] from edge E1+k·TICK_DIV. Each code is held for exactly TICK_DIV cycles.
- ISSUE (one cycle): compare dout_fb with din_out.
  - Equal, or din_out == 3'b000 (the FSM's default output is indistinguishable from a valid return to S0): step accepted, go to WAIT.
  - Otherwise: err_idx = cur_idx, go to ERROR.
- WAIT (TICK_DIV−1 cycles, internal counter):
  - At expiry, if cur_idx == count−1, go to DONE.
  - Otherwise cur_idx+1, din_out = route[cur_idx+1], go to ISSUE.
- din_out holding: din_out is never returned to an idle value. It keeps the last code in DONE/ERROR/IDLE. This is safe because the navigation FSM's accepted code c always leads to state c, and c is stable in state c.
- DONE/ERROR:
  - Flags are held until start or clear.
  - err, done are mutually exclusive.
- abort in ISSUE/WAIT:
  - Next state IDLE, count kept, din_out held.
  - No done/err is asserted.
- clear in any state:
  - count = 0, cur_idx = 0, flags = 0, IDLE.
  - din_out is held.
- Same-cycle priority: clear > abort > start > wr_en.
  - clear+wr_en: the write is dropped.
  - start+wr_en in IDLE: start taken, write dropped.
- ERROR on index 0 is possible, e.g. the first code is illegal from the FSM's current state.
- Reset mid-playback: immediate return to reset values. The paired navigation FSM must share rstn so both restart at S0.

Test Plan:
- Basic playback: reset, write 001,010,011,000, start with TICK_DIV=4 driving a real navigation FSM model.
  - Required: din_out = 001/010/011/000 starting at E1/E5/E9/E13.
  - Required: done=1 from E17, err=0, FSM ends in S0.
- Rejected step: route 001,011, FSM in S0.
  - Required: at E5 dout_fb = 000 ≠ 011, so err=1, err_idx=1, busy=0 and done=0 thereafter.
  - Required: din_out stays 011 and the FSM stays in S1.
- Capacity: write 9 codes with DEPTH=8.
  - Required: count=8, full=1, 9th write dropped.
  - Required: wr_en during busy is dropped, count unchanged.
- Control: abort at E6 of a 4-step route.
  - Required: IDLE at E7, count=4, din_out held.
  - Then start: replay from index 0 at E8+1.
  - clear+abort+start in one cycle: IDLE, count=0.
- Boundaries:
  - start with count=0: no change.
  - start in DONE: restart from index 0.
  - rstn pulse mid-WAIT: all outputs go to reset values asynchronously, before the next clock edge.
